sva_seq_driver: RTL



---
 rtl/sva_seq_driver_if.sv | 46 ++++
 rtl/sva_seq_driver.sv | 123 ++++++++++++
 2 files changed

// File: rtl/sva_seq_driver_if.sv
// sva_seq_driver_if: config, control and status bundle for sva_seq_driver.
// Fault-injection signals exist only when SEQ_DRV_INJECT_EN is defined.
interface sva_seq_driver_if #(
  parameter int SIG_W = 3,
  parameter int MAX_STEPS = 8,
  parameter int DLY_W = 4,
  parameter int REP_W = 8,
  parameter int IDX_W = $clog2(MAX_STEPS)
);
  logic cfg_we;
  logic [IDX_W-1:0] cfg_idx;
  logic [SIG_W-1:0] cfg_pat;
  logic [DLY_W-1:0] cfg_dly;
  logic [IDX_W:0] cfg_len;
  logic [REP_W-1:0] rep_cnt;
  logic [SIG_W-1:0] idle_pat;
  logic start;
  logic abort;
  logic [SIG_W-1:0] sig_out;
  logic busy;
  logic [IDX_W-1:0] step_idx;
  logic seq_done;
  logic all_done;
`ifdef SEQ_DRV_INJECT_EN
  logic inj_en;
  logic [IDX_W-1:0] inj_step;
  logic [SIG_W-1:0] inj_mask;
  logic exp_fail;
`endif
  modport master (
    output cfg_we, cfg_idx, cfg_pat, cfg_dly, cfg_len, rep_cnt, idle_pat, start, abort,
`ifdef SEQ_DRV_INJECT_EN
    output inj_en, inj_step, inj_mask,
    input exp_fail,
`endif
    input sig_out, busy, step_idx, seq_done, all_done
  );
  modport slave (
    input cfg_we, cfg_idx, cfg_pat, cfg_dly, cfg_len, rep_cnt, idle_pat, start, abort,
`ifdef SEQ_DRV_INJECT_EN
    input inj_en, inj_step, inj_mask,
    output exp_fail,
`endif
    output sig_out, busy, step_idx, seq_done, all_done
  );
endinterface

// File: rtl/sva_seq_driver.sv
// sva_seq_driver: plays a table of patterns with per-step idle gaps onto sig_out, repeated rep_cnt+1 times.
// Optional SEQ_DRV_INJECT_EN: XOR-corrupts one step per pass and flags exp_fail.
module sva_seq_driver #(
  parameter int SIG_W = 3,
  parameter int MAX_STEPS = 8,
  parameter int DLY_W = 4,
  parameter int REP_W = 8,
  parameter int IDX_W = $clog2(MAX_STEPS)
) (
  input logic gclk,
  input logic grst,
  sva_seq_driver_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} st_t;
  st_t st;
  logic [SIG_W-1:0] pat_t [MAX_STEPS];
  logic [SIG_W-1:0] pat_v [MAX_STEPS];
  logic [DLY_W-1:0] dly_t [MAX_STEPS];
  logic [DLY_W-1:0] dly_v [MAX_STEPS];
  logic [DLY_W-1:0] cnt, cur_cnt;
  logic [IDX_W-1:0] step, nxt_step;
  logic [IDX_W:0] len_q, cur_len;
  logic [REP_W-1:0] pass, cur_pass;
  logic [SIG_W-1:0] inj_x, drv_pat;
  logic idle, go, last, wrap;
  assign idle = st == IDLE;
  assign go = !bus.abort && (idle ? bus.start && bus.cfg_len != '0 : st == RUN);
  // The accepting edge already times step 0, so a same-cycle write must be visible here
  always_comb begin
    pat_v = pat_t;
    dly_v = dly_t;
    if (idle && bus.cfg_we) begin
      pat_v[bus.cfg_idx] = bus.cfg_pat;
      dly_v[bus.cfg_idx] = bus.cfg_dly;
    end
  end
  assign cur_cnt = idle ? dly_v[0] : cnt;
  assign cur_len = idle ? bus.cfg_len : len_q;
  assign cur_pass = idle ? bus.rep_cnt : pass;
  assign last = {1'b0, step} == cur_len - (IDX_W+1)'(1);
  assign nxt_step = last ? '0 : step + IDX_W'(1);
  assign drv_pat = pat_v[step] ^ inj_x;
  assign bus.step_idx = step;
`ifdef SEQ_DRV_INJECT_EN
  logic inj_en_q, hit;
  logic [IDX_W-1:0] inj_step_q;
  logic [SIG_W-1:0] inj_mask_q;
  assign inj_x = (idle ? bus.inj_en && step == bus.inj_step : inj_en_q && step == inj_step_q)
               ? (idle ? bus.inj_mask : inj_mask_q) : '0;
  always_ff @(posedge gclk or posedge grst)
    if (grst) begin
      inj_en_q <= 1'b0;
      inj_step_q <= '0;
      inj_mask_q <= '0;
      hit <= 1'b0;
      bus.exp_fail <= 1'b0;
    end else begin
      hit <= go && cur_cnt == '0 && inj_x != '0;
      bus.exp_fail <= (idle || bus.abort) ? 1'b0 : bus.exp_fail | hit;
      if (idle && go) begin
        inj_en_q <= bus.inj_en;
        inj_step_q <= bus.inj_step;
        inj_mask_q <= bus.inj_mask;
      end
    end
`else
  assign inj_x = '0;
`endif
  always_ff @(posedge gclk or posedge grst)
    if (grst) begin
      st <= IDLE;
      bus.sig_out <= '0;
      bus.busy <= 1'b0;
      bus.seq_done <= 1'b0;
      bus.all_done <= 1'b0;
      step <= '0;
      cnt <= '0;
      len_q <= '0;
      pass <= '0;
      wrap <= 1'b0;
      for (int i = 0; i < MAX_STEPS; i++) begin
        pat_t[i] <= '0;
        dly_t[i] <= '0;
      end
    end else begin
      bus.sig_out <= bus.idle_pat;
      bus.seq_done <= st == RUN && wrap && !bus.abort;
      bus.all_done <= 1'b0;
      wrap <= 1'b0;
      if (idle && bus.cfg_we) begin
        pat_t[bus.cfg_idx] <= bus.cfg_pat;
        dly_t[bus.cfg_idx] <= bus.cfg_dly;
      end
      if (bus.abort || st != RUN) begin
        st <= IDLE;
        bus.busy <= 1'b0;
        step <= '0;
      end
      if (st == DONE && !bus.abort) begin
        bus.busy <= 1'b1;
        bus.seq_done <= 1'b1;
        bus.all_done <= 1'b1;
      end
      if (go) begin
        bus.busy <= 1'b1;
        st <= RUN;
        if (idle) begin
          len_q <= bus.cfg_len;
          pass <= bus.rep_cnt;
        end
        if (cur_cnt != '0)
          cnt <= cur_cnt - DLY_W'(1);
        else begin
          bus.sig_out <= drv_pat;
          step <= nxt_step;
          cnt <= dly_v[nxt_step];
          wrap <= last && cur_pass != '0;
          if (last && cur_pass != '0) pass <= cur_pass - REP_W'(1);
          if (last && cur_pass == '0) st <= DONE;
        end
      end
    end
endmodule
